// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the ID/EX pipeline register bundle.
package alu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;
    localparam int REG_ADDR_W    = 5;

    typedef enum logic [OPCODE_LENGTH-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_BEQ = 4'b1000
    } alu_op_e;

    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_W-1:0]    rs1;
        logic [REG_ADDR_W-1:0]    rs2;
        logic [REG_ADDR_W-1:0]    rd;
        logic [DATA_WIDTH-1:0]    rd1;
        logic [DATA_WIDTH-1:0]    rd2;
        logic [DATA_WIDTH-1:0]    imm;
        logic                     alusrc;
        logic [OPCODE_LENGTH-1:0] aluop;
        logic                     regwrite;
        logic                     memread;
    } ex_reg_t;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding: MEM beats WB beats register file; x0 never forwarded.
module forward_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  mem_regwrite_i,
    input  logic [DATA_WIDTH-1:0] mem_result_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  wb_regwrite_i,
    input  logic [DATA_WIDTH-1:0] wb_result_i,
    output logic [DATA_WIDTH-1:0] fwd_data_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
    assign wb_hit  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);

    always_comb begin
        fwd_data_o = rf_data_i;
        if (mem_hit) begin
            fwd_data_o = mem_result_i;
        end else if (wb_hit) begin
            fwd_data_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbles and operand forwarding.
// DATA_WIDTH/OPCODE_LENGTH must match the alu_pkg values, which size the register bundle.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = alu_pkg::DATA_WIDTH,
    parameter int OPCODE_LENGTH = alu_pkg::OPCODE_LENGTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [4:0]               id_rs1,
    input  logic [4:0]               id_rs2,
    input  logic [4:0]               id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rd1,
    input  logic [DATA_WIDTH-1:0]    id_rd2,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alusrc,
    input  logic [OPCODE_LENGTH-1:0] id_aluop,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     ex_flush,
    input  logic [4:0]               mem_rd,
    input  logic                     mem_regwrite,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [4:0]               wb_rd,
    input  logic                     wb_regwrite,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ex_valid,
    output logic [4:0]               ex_rd,
    output logic                     ex_regwrite,
    output logic                     ex_memread,
    output logic                     stall
);

    ex_reg_t               ex_q;
    ex_reg_t               ex_d;
    logic                  hazard;
    logic                  bubble;
    logic [DATA_WIDTH-1:0] fwd_b;

    // A load in EX whose destination feeds the decode-stage instruction.
    assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    assign stall  = hazard && !ex_flush;
    assign bubble = ex_flush || hazard;

    always_comb begin
        ex_d.valid    = id_valid;
        ex_d.rs1      = id_rs1;
        ex_d.rs2      = id_rs2;
        ex_d.rd       = id_rd;
        ex_d.rd1      = id_rd1;
        ex_d.rd2      = id_rd2;
        ex_d.imm      = id_imm;
        ex_d.alusrc   = id_alusrc;
        ex_d.aluop    = id_aluop;
        ex_d.regwrite = id_regwrite;
        ex_d.memread  = id_memread;
        if (bubble) begin
            ex_d.valid    = 1'b0;
            ex_d.rd       = '0;
            ex_d.aluop    = ALU_AND;
            ex_d.regwrite = 1'b0;
            ex_d.memread  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
        .rs_i           (ex_q.rs1),
        .rf_data_i      (ex_q.rd1),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_result_i   (mem_result),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_result_i    (wb_result),
        .fwd_data_o     (SrcA)
    );

    forward_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
        .rs_i           (ex_q.rs2),
        .rf_data_i      (ex_q.rd2),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_result_i   (mem_result),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_result_i    (wb_result),
        .fwd_data_o     (fwd_b)
    );

    assign SrcB        = ex_q.alusrc ? ex_q.imm : fwd_b;
    assign Operation   = ex_q.aluop;
    assign ex_valid    = ex_q.valid;
    assign ex_rd       = ex_q.rd;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic        id_alusrc;
    logic [3:0]  id_aluop;
    logic        id_regwrite, id_memread, ex_flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_result, wb_result;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread, stall;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .stall(stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alusrc = 0;
        id_aluop = 0; id_regwrite = 0; id_memread = 0; ex_flush = 0;
        mem_rd = 0; mem_regwrite = 0; mem_result = 0;
        wb_rd = 0; wb_regwrite = 0; wb_result = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic alusrc, input logic [3:0] op, input logic rw, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alusrc = alusrc;
        id_aluop = op; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        #1;
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
        tests++; if (Operation !== 4'b0000) begin fails++; $display("FAIL reset_op got %b want 0000", Operation); end
        tests++; if ({ex_rd, ex_regwrite, ex_memread, stall} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl got rd=%0d rw=%0b mr=%0b st=%0b want all 0", ex_rd, ex_regwrite, ex_memread, stall);
        end
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_add;
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0);
        tick();
        id_valid = 0;
        tests++; if (SrcA !== 32'd5) begin fails++; $display("FAIL add_srca got %0d want 5", SrcA); end
        tests++; if (SrcB !== 32'd7) begin fails++; $display("FAIL add_srcb got %0d want 7", SrcB); end
        tests++; if (Operation !== 4'b0010) begin fails++; $display("FAIL add_op got %b want 0010", Operation); end
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_regwrite !== 1'b1) begin
            fails++; $display("FAIL add_ctrl got v=%0b rd=%0d rw=%0b want 1/5/1", ex_valid, ex_rd, ex_regwrite);
        end
    endtask

    task automatic test_fwd_priority;
        clear_inputs();
        set_id(5'd3, 5'd3, 5'd7, 32'hAAAA, 32'hBBBB, 32'h77, 1'b1, ALU_OR, 1'b1, 1'b0);
        tick();
        id_valid = 0;
        mem_rd = 3; mem_regwrite = 1; mem_result = 32'h10;
        wb_rd = 3; wb_regwrite = 1; wb_result = 32'h20;
        #1;
        tests++; if (SrcA !== 32'h10) begin fails++; $display("FAIL fwd_mem_prio got %h want 10", SrcA); end
        tests++; if (SrcB !== 32'h77) begin fails++; $display("FAIL fwd_imm_sel got %h want 77", SrcB); end
        mem_regwrite = 0;
        #1;
        tests++; if (SrcA !== 32'h20) begin fails++; $display("FAIL fwd_wb got %h want 20", SrcA); end
        wb_regwrite = 0;
        #1;
        tests++; if (SrcA !== 32'hAAAA) begin fails++; $display("FAIL fwd_rf got %h want aaaa", SrcA); end
    endtask

    task automatic test_load_use;
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h8, 1'b1, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(5'd1, 5'd4, 5'd6, 32'h11, 32'h999, 32'h0, 1'b0, ALU_SUB, 1'b1, 1'b0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %0b want 1", stall); end
        tick();
        tests++; if (ex_valid !== 1'b0 || Operation !== 4'b0000 || ex_rd !== 5'd0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0) begin
            fails++; $display("FAIL lu_bubble got v=%0b op=%b rd=%0d rw=%0b mr=%0b want 0", ex_valid, Operation, ex_rd, ex_regwrite, ex_memread);
        end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_one_stall got %0b want 0", stall); end
        wb_rd = 4; wb_regwrite = 1; wb_result = 32'h1234;
        tick();
        id_valid = 0;
        tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || Operation !== 4'b0011) begin
            fails++; $display("FAIL lu_issue got v=%0b rd=%0d op=%b want 1/6/0011", ex_valid, ex_rd, Operation);
        end
        tests++; if (SrcB !== 32'h1234) begin fails++; $display("FAIL lu_fwd_wb got %h want 1234", SrcB); end
        tests++; if (SrcA !== 32'h11) begin fails++; $display("FAIL lu_srca got %h want 11", SrcA); end
    endtask

    task automatic test_x0;
        clear_inputs();
        set_id(5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 1'b0, ALU_XOR, 1'b1, 1'b0);
        tick();
        id_valid = 0;
        mem_rd = 0; mem_regwrite = 1; mem_result = 32'hFF;
        wb_rd = 0; wb_regwrite = 1; wb_result = 32'hEE;
        #1;
        tests++; if (SrcA !== 32'h0) begin fails++; $display("FAIL x0_srca got %h want 0", SrcA); end
        tests++; if (SrcB !== 32'h0) begin fails++; $display("FAIL x0_srcb got %h want 0", SrcB); end
    endtask

    task automatic test_flush_hazard_reset;
        clear_inputs();
        set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h0, 1'b1, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(5'd4, 5'd2, 5'd8, 32'h5, 32'h6, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0);
        ex_flush = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall got %0b want 0", stall); end
        tick();
        ex_flush = 0;
        tests++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            fails++; $display("FAIL flush_bubble got v=%0b rw=%0b want 0/0", ex_valid, ex_regwrite);
        end
        set_id(5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 32'h0, 1'b0, ALU_BEQ, 1'b1, 1'b0);
        tick();
        tests++; if (ex_valid !== 1'b1 || Operation !== 4'b1000) begin
            fails++; $display("FAIL flush_resume got v=%0b op=%b want 1/1000", ex_valid, Operation);
        end
        #2 rst_n = 0;
        #1;
        tests++; if (ex_valid !== 1'b0 || Operation !== 4'b0000 || ex_rd !== 5'd0 || ex_regwrite !== 1'b0) begin
            fails++; $display("FAIL async_reset got v=%0b op=%b rd=%0d rw=%0b want 0", ex_valid, Operation, ex_rd, ex_regwrite);
        end
        tick();
        rst_n = 1;
        // load in EX with a dependent decode instruction, then reset mid-hazard
        set_id(5'd1, 5'd2, 5'd4, 32'h0, 32'h0, 32'h0, 1'b1, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(5'd4, 5'd4, 5'd8, 32'h0, 32'h0, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL prereset_stall got %0b want 1", stall); end
        rst_n = 0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_drops_stall got %0b want 0", stall); end
        tick();
        rst_n = 1;
        clear_inputs();
        tick();
    endtask

    // Reference model: what EX should hold, derived from the stage's rules.
    logic        m_valid, m_alusrc, m_rw, m_mr;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [3:0]  m_op;

    function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return mem_result;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_result;
        return rf;
    endfunction

    task automatic test_random;
        logic exp_hz, exp_stall;
        logic [31:0] exp_a, exp_b;
        m_valid = 0; m_alusrc = 0; m_rw = 0; m_mr = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_op = 0;
        rst_n = 0;
        #1;
        rst_n = 1;
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            id_alusrc = 1'($urandom_range(0, 1)); id_aluop = 4'($urandom_range(0, 15));
            id_regwrite = 1'($urandom_range(0, 1)); id_memread = ($urandom_range(0, 2) == 0);
            ex_flush = ($urandom_range(0, 7) == 0);
            mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom_range(0, 1)); mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom_range(0, 1)); wb_result = $urandom;
            #1;
            exp_hz = m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
            exp_stall = exp_hz && !ex_flush;
            exp_a = model_fwd(m_rs1, m_rd1);
            exp_b = m_alusrc ? m_imm : model_fwd(m_rs2, m_rd2);
            tests++; if (stall !== exp_stall) begin fails++; $display("FAIL rnd_stall[%0d] got %0b want %0b", i, stall, exp_stall); end
            tests++; if ({ex_valid, ex_rd, ex_regwrite, ex_memread, Operation} !== {m_valid, m_rd, m_rw, m_mr, m_op}) begin
                fails++; $display("FAIL rnd_ctrl[%0d] got v=%0b rd=%0d rw=%0b mr=%0b op=%b want v=%0b rd=%0d rw=%0b mr=%0b op=%b",
                                  i, ex_valid, ex_rd, ex_regwrite, ex_memread, Operation, m_valid, m_rd, m_rw, m_mr, m_op);
            end
            if (m_valid) begin
                tests++; if (SrcA !== exp_a) begin fails++; $display("FAIL rnd_srca[%0d] got %h want %h", i, SrcA, exp_a); end
                tests++; if (SrcB !== exp_b) begin fails++; $display("FAIL rnd_srcb[%0d] got %h want %h", i, SrcB, exp_b); end
            end
            @(posedge clk);
            if (ex_flush || exp_hz) begin
                m_valid = 0; m_rd = 0; m_rw = 0; m_mr = 0; m_op = 0;
            end else begin
                m_valid = id_valid; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
                m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_alusrc = id_alusrc;
                m_op = id_aluop; m_rw = id_regwrite; m_mr = id_memread;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        test_reset();
        test_add();
        test_fwd_priority();
        test_load_use();
        test_x0();
        test_flush_hazard_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 DATA_WIDTH, 32, operand/result width; OPCODE_LENGTH, 4, ALU operation code width; register addresses fixed at 5 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports exactly as follows:
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_rs1  in  5  source register 1 index.
REQ-007 id_rs2  in  5  source register 2 index.
REQ-008 id_rd  in  5  destination register index.
REQ-009 id_rd1  in  DATA_WIDTH  register-file read data 1.
REQ-010 id_rd2  in  DATA_WIDTH  register-file read data 2.
REQ-011 id_imm  in  DATA_WIDTH  sign-extended immediate.
REQ-012 id_alusrc  in  1  1 selects immediate as SrcB.
REQ-013 id_aluop  in  OPCODE_LENGTH  decoded ALU operation.
REQ-014 id_regwrite  in  1  instruction writes rd.
REQ-015 id_memread  in  1  instruction is a load.
REQ-016 ex_flush  in  1  taken branch; squash the decode-stage instruction.
REQ-017 mem_rd  in  5  EX/MEM destination index.
REQ-018 mem_regwrite  in  1  EX/MEM writes rd.
REQ-019 mem_result  in  DATA_WIDTH  EX/MEM ALU result.
REQ-020 wb_rd  in  5  MEM/WB destination index.
REQ-021 wb_regwrite  in  1  MEM/WB writes rd.
REQ-022 wb_result  in  DATA_WIDTH  MEM/WB write-back value.
REQ-023 SrcA  out  DATA_WIDTH  forwarded ALU operand A.
REQ-024 SrcB  out  DATA_WIDTH  forwarded operand B or immediate.
REQ-025 Operation  out  OPCODE_LENGTH  registered ALU operation.
REQ-026 ex_valid  out  1  EX stage holds a real instruction.
REQ-027 ex_rd / ex_regwrite / ex_memread  out  5/1/1  registered destination controls.
REQ-028 stall  out  1  combinational hold request to PC and IF/ID.

Function
REQ-029 Each rising edge SHALL capture all id_* fields into EX registers, unless a bubble is inserted.
REQ-030 A load-use hazard SHALL be detected when: ex_valid, ex_memread, ex_rd!=0, id_valid, and ex_rd equals id_rs1 or id_rs2.
REQ-031 stall SHALL equal hazard AND NOT ex_flush.
REQ-032 Bubble insertion occurs on ex_flush or hazard: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=0, Operation=0000; data registers are don't-care.
REQ-033 ex_flush SHALL take priority over hazard when both are active in the same cycle.
REQ-034 Each hazard SHALL produce exactly one stall cycle; the following cycle, the bubble in EX clears the hazard.
REQ-035 Forward A/B (combinational): the MEM stage SHALL be used if mem_regwrite, mem_rd!=0, and mem_rd==ex_rs; otherwise the WB stage SHALL be used under the same conditions; otherwise the registered register-file value SHALL be used.
REQ-036 The MEM stage SHALL take priority over the WB stage when both match; x0 SHALL never be forwarded.
REQ-037 SrcB SHALL equal ex_imm when ex_alusrc=1; otherwise it SHALL equal forwarded operand B.
REQ-038 Latency SHALL be one cycle from ID capture to SrcA/SrcB/Operation; no arithmetic is performed.

Reset
REQ-039 Asserting rst_n low SHALL immediately clear all EX registers: ex_valid=0, Operation=0000, ex_rd=0, all control outputs 0, stall=0. Reset during a hazard SHALL discard the stall.

Structure
REQ-040 The ALU operation codes SHALL reside in the shared package alu_pkg: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, BEQ 1000. The EX register bundle struct SHALL also reside in alu_pkg.
REQ-041 The block SHALL contain one sub-module, forward_unit, which is combinational and is instantiated once per operand.

Verification
REQ-042 A bench SHALL cover: ADD with rd1=5, rd2=7, alusrc=0 -> next cycle SrcA=5, SrcB=7, Operation=0010.
REQ-043 A bench SHALL cover: mem_rd=3, mem_result=0x10 and wb_rd=3, wb_result=0x20, with ex_rs1=3 -> SrcA=0x10.
REQ-044 A bench SHALL cover: a load to x4 in EX with id_rs2=4 -> stall=1 for one cycle and a bubble; then wb_result forwarded to SrcB.
REQ-045 A bench SHALL cover: mem_rd=0, mem_regwrite=1, mem_result=0xFF, ex_rs1=0 -> SrcA=id_rd1 captured value (0).
REQ-046 A bench SHALL cover: hazard and ex_flush in the same cycle -> stall=0, ex_valid=0 next cycle; then rst_n low mid-stream -> outputs cleared asynchronously.
